// File: rtl/irig_b_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// irig_b_frame_ctrl_if
// Byte-stream bundle between the UART pair and the IRIG-B frame controller.
//
//   rx_data  [7:0]  received symbol byte (UART receiver -> controller)
//   rx_valid        one-cycle strobe qualifying rx_data
//   tx_data  [7:0]  report byte (controller -> UART transmitter)
//   tx_valid        tx_data valid, held until accepted
//   tx_ready        transmitter can take tx_data this cycle
//
// Handshake: the rx side has no back-pressure, so every rx_valid cycle is one
// symbol. The tx side is valid/ready: a byte transfers on a rising clk edge
// where tx_valid & tx_ready are both high; once tx_valid is raised it stays
// high and tx_data stays constant until that transfer happens.
//
// modport master : UART side (drives rx and tx_ready)
// modport slave  : frame controller
// ---------------------------------------------------------------------------
interface irig_b_frame_ctrl_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output rx_data,
      output rx_valid,
      output tx_ready,
      input  tx_data,
      input  tx_valid
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  tx_ready,
      output tx_data,
      output tx_valid
   );
endinterface

// File: rtl/irig_b_frame_ctrl.sv
// ---------------------------------------------------------------------------
// irig_b_frame_ctrl
// Locks to an IRIG-B frame delivered as ASCII symbols ('P' marker, '0'/'1'
// data), tracks the symbol index 0..99, decodes the BCD time-of-year at the
// marker on index 49 and optionally emits a 14-byte "DDD HH:MM:SS\r\n"
// report through a valid/ready byte stream.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   bus          irig_b_frame_ctrl_if.slave (rx symbols in, tx report out)
//   locked       high while the sync FSM is LOCKED
//   sym_err      one-cycle pulse on a framing or symbol error
//   time_valid   one-cycle pulse in the cycle the time fields change
//   sec_bcd, min_bcd, hour_bcd, day_bcd   decoded BCD time fields
//   overrun      sticky: a publish arrived while a report was still going out
//   sync_state   debug view of the sync FSM state (0 HUNT, 1 ARMED, 2 LOCKED)
// Parameter:
//   REPORT_EN    1 = send a report on each publish, 0 = tx_valid never rises
// ---------------------------------------------------------------------------
module irig_b_frame_ctrl #(
   parameter bit REPORT_EN = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   irig_b_frame_ctrl_if.slave        bus,
   output logic                      locked,
   output logic                      sym_err,
   output logic                      time_valid,
   output logic [6:0]                sec_bcd,
   output logic [6:0]                min_bcd,
   output logic [5:0]                hour_bcd,
   output logic [9:0]                day_bcd,
   output logic                      overrun,
   output logic [1:0]                sync_state
);

   typedef enum logic [1:0] {
      S_HUNT   = 2'd0,
      S_ARMED  = 2'd1,
      S_LOCKED = 2'd2
   } sync_state_t;

   sync_state_t state, state_next;
   logic [6:0]  idx, idx_next;
   logic [6:0]  pos;
   logic        is_p, is_bit, is_ign, at_marker;
   logic        err_next, publish, store_bit;
   logic [48:1] frame_bits;
   logic        unused_frame;

   logic [6:0]  pub_sec, pub_min;
   logic [5:0]  pub_hour;
   logic [9:0]  pub_day;

   logic        rpt_start, tx_valid_q, busy;
   logic [3:0]  byte_idx;
   logic [6:0]  snap_sec, snap_min;
   logic [5:0]  snap_hour;
   logic [9:0]  snap_day;
   logic [7:0]  byte_mux;

   function automatic logic marker_pos(input logic [6:0] p);
      case (p)
         7'd9, 7'd19, 7'd29, 7'd39, 7'd49,
         7'd59, 7'd69, 7'd79, 7'd89, 7'd99: return 1'b1;
         default:                           return 1'b0;
      endcase
   endfunction

   function automatic logic [7:0] digit(input logic [3:0] n);
      return 8'h30 + {4'h0, n};
   endfunction

   // idx holds the index of the last accepted symbol; the symbol now arriving
   // sits one position further on.
   assign pos       = idx + 7'd1;
   assign is_p      = (bus.rx_data == 8'h50);
   assign is_bit    = (bus.rx_data == 8'h30) || (bus.rx_data == 8'h31);
   assign is_ign    = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
   assign at_marker = marker_pos(pos);

   // Positions such as 5, 14, 18 and 42..48 are kept but never decoded.
   assign unused_frame = ^frame_bits;

   assign pub_sec  = {frame_bits[8], frame_bits[7], frame_bits[6], frame_bits[4:1]};
   assign pub_min  = {frame_bits[17:15], frame_bits[13:10]};
   assign pub_hour = {frame_bits[26:25], frame_bits[23:20]};
   assign pub_day  = {frame_bits[41:40], frame_bits[38:35], frame_bits[33:30]};

   // ------------------------------------------------------------------ sync FSM
   always_comb begin
      state_next = state;
      idx_next   = idx;
      err_next   = 1'b0;
      publish    = 1'b0;
      store_bit  = 1'b0;
      if (bus.rx_valid && !is_ign) begin
         case (state)
            S_HUNT: begin
               if (is_p) state_next = S_ARMED;
            end
            S_ARMED: begin
               if (is_p) begin
                  state_next = S_LOCKED;
                  idx_next   = 7'd0;
               end else begin
                  state_next = S_HUNT;
                  err_next   = !is_bit;
               end
            end
            S_LOCKED: begin
               idx_next = pos;
               if (is_p && at_marker) begin
                  // The frame-end marker re-arms so the following P is index 0.
                  if (pos == 7'd99) state_next = S_ARMED;
                  if (pos == 7'd49) publish = 1'b1;
               end else if (is_bit && !at_marker) begin
                  store_bit = (pos <= 7'd48);
               end else begin
                  err_next   = 1'b1;
                  state_next = is_p ? S_ARMED : S_HUNT;
               end
            end
            default: state_next = S_HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_HUNT;
         idx        <= 7'd0;
         frame_bits <= '0;
         sym_err    <= 1'b0;
         time_valid <= 1'b0;
         sec_bcd    <= 7'd0;
         min_bcd    <= 7'd0;
         hour_bcd   <= 6'd0;
         day_bcd    <= 10'd0;
      end else begin
         state      <= state_next;
         idx        <= idx_next;
         sym_err    <= err_next;
         time_valid <= publish;
         if (store_bit) frame_bits[pos[5:0]] <= bus.rx_data[0];
         if (publish) begin
            sec_bcd  <= pub_sec;
            min_bcd  <= pub_min;
            hour_bcd <= pub_hour;
            day_bcd  <= pub_day;
         end
      end
   end

   assign locked     = (state == S_LOCKED);
   assign sync_state = state;

   // ---------------------------------------------------------- report sequencer
   // rpt_start delays the first byte by one cycle so tx_valid rises the cycle
   // after time_valid. A report, once started, always runs to byte 13 unless
   // rst intervenes; sync errors do not touch it.
   assign busy = rpt_start | tx_valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rpt_start  <= 1'b0;
         tx_valid_q <= 1'b0;
         byte_idx   <= 4'd0;
         overrun    <= 1'b0;
         snap_sec   <= 7'd0;
         snap_min   <= 7'd0;
         snap_hour  <= 6'd0;
         snap_day   <= 10'd0;
      end else begin
         rpt_start <= 1'b0;
         if (publish && REPORT_EN) begin
            if (busy) begin
               overrun <= 1'b1;
            end else begin
               rpt_start <= 1'b1;
               snap_sec  <= pub_sec;
               snap_min  <= pub_min;
               snap_hour <= pub_hour;
               snap_day  <= pub_day;
            end
         end
         if (rpt_start) begin
            tx_valid_q <= 1'b1;
            byte_idx   <= 4'd0;
         end else if (tx_valid_q && bus.tx_ready) begin
            if (byte_idx == 4'd13) begin
               tx_valid_q <= 1'b0;
               byte_idx   <= 4'd0;
            end else begin
               byte_idx <= byte_idx + 4'd1;
            end
         end
      end
   end

   always_comb begin
      byte_mux = 8'h00;
      case (byte_idx)
         4'd0:    byte_mux = digit({2'b00, snap_day[9:8]});
         4'd1:    byte_mux = digit(snap_day[7:4]);
         4'd2:    byte_mux = digit(snap_day[3:0]);
         4'd3:    byte_mux = 8'h20;
         4'd4:    byte_mux = digit({2'b00, snap_hour[5:4]});
         4'd5:    byte_mux = digit(snap_hour[3:0]);
         4'd6:    byte_mux = 8'h3A;
         4'd7:    byte_mux = digit({1'b0, snap_min[6:4]});
         4'd8:    byte_mux = digit(snap_min[3:0]);
         4'd9:    byte_mux = 8'h3A;
         4'd10:   byte_mux = digit({1'b0, snap_sec[6:4]});
         4'd11:   byte_mux = digit(snap_sec[3:0]);
         4'd12:   byte_mux = 8'h0D;
         4'd13:   byte_mux = 8'h0A;
         default: byte_mux = 8'h00;
      endcase
   end

   assign bus.tx_valid = tx_valid_q;
   assign bus.tx_data  = tx_valid_q ? byte_mux : 8'h00;

endmodule

// File: tb/tb_irig_b_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irig_b_frame_ctrl
// Directed-vector bench for irig_b_frame_ctrl. Stimulus pushes expected time
// words, report bytes and error outcomes into queues; a monitor on the
// falling edge pops and compares whenever the DUT presents them.
// ---------------------------------------------------------------------------
module tb_irig_b_frame_ctrl;

   // ---------------------------------------------------- clock / reset block
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;

   irig_b_frame_ctrl_if uart_if ();

   logic       locked, sym_err, time_valid, overrun;
   logic [6:0] sec_bcd, min_bcd;
   logic [5:0] hour_bcd;
   logic [9:0] day_bcd;
   logic [1:0] sync_state;

   irig_b_frame_ctrl #(.REPORT_EN(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (uart_if),
      .locked     (locked),
      .sym_err    (sym_err),
      .time_valid (time_valid),
      .sec_bcd    (sec_bcd),
      .min_bcd    (min_bcd),
      .hour_bcd   (hour_bcd),
      .day_bcd    (day_bcd),
      .overrun    (overrun),
      .sync_state (sync_state)
   );

   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_ARMED  = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   // {sec, min, hour, day}
   localparam logic [29:0] TIME_A = {7'h08, 7'h48, 6'h01, 10'h051};
   localparam logic [29:0] TIME_B = {7'h08, 7'h48, 6'h01, 10'h151};
   localparam logic [7:0]  RPT_A [0:13] = '{8'h30, 8'h35, 8'h31, 8'h20, 8'h30, 8'h31, 8'h3A,
                                            8'h34, 8'h38, 8'h3A, 8'h30, 8'h38, 8'h0D, 8'h0A};

   // ------------------------------------------------------------ scoreboard
   int total = 0;
   int bad   = 0;
   logic [29:0] time_q[$];
   logic [7:0]  tx_q[$];
   logic [1:0]  err_q[$];   // expected sync_state after each sym_err
   int tx_mode = 0;         // 0 ready low, 1 ready high, 2 ready 1-in-3

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------- driver tasks
   task automatic send_sym(input logic [7:0] b);
      @(posedge clk); #1;
      uart_if.rx_data  = b;
      uart_if.rx_valid = 1'b1;
      @(posedge clk); #1;
      uart_if.rx_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_sym(s[i]);
   endtask

   // Positions 1..49 of the reference frame; CR/LF are slipped in after
   // marker 9 and must not consume an index.
   task automatic send_frame_a();
      send_str("00010000P");
      send_sym(8'h0D);
      send_sym(8'h0A);
      send_str("000100010P100000000P100001010P000000000P");
   endtask

   task automatic send_frame_b();
      send_str("00010000P000100010P100000000P100001010P100000000P");
   endtask

   task automatic push_report_a();
      for (int i = 0; i < 14; i++) tx_q.push_back(RPT_A[i]);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      uart_if.rx_valid = 1'b0;
      time_q.delete();
      tx_q.delete();
      err_q.delete();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_tx_done(input int budget);
      int n = 0;
      while ((tx_q.size() != 0 || uart_if.tx_valid) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check("tx_done_in_budget", {31'd0, (n < budget)}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   // tx_ready pattern generator
   initial begin
      int ph;
      ph = 0;
      uart_if.tx_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (tx_mode)
            1: uart_if.tx_ready = 1'b1;
            2: begin
               uart_if.tx_ready = (ph == 0);
               ph = (ph + 1) % 3;
            end
            default: uart_if.tx_ready = 1'b0;
         endcase
      end
   end

   // --------------------------------------------------------------- monitor
   initial begin
      logic       prev_stall, chk_rise, chk_drop;
      logic [7:0] prev_data;
      prev_stall = 1'b0;
      chk_rise   = 1'b0;
      chk_drop   = 1'b0;
      prev_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
            chk_rise   = 1'b0;
            chk_drop   = 1'b0;
         end else begin
            if (chk_rise) check("tx_valid_rise", {31'd0, uart_if.tx_valid}, 32'd1);
            if (chk_drop) check("tx_valid_drop", {31'd0, uart_if.tx_valid}, 32'd0);
            if (prev_stall) check("tx_data_stall", {24'd0, uart_if.tx_data}, {24'd0, prev_data});
            chk_rise = time_valid && !uart_if.tx_valid;
            chk_drop = 1'b0;
            if (uart_if.tx_valid && uart_if.tx_ready) begin
               if (tx_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL tx_byte: got 0x%0h expected no byte at %0t", uart_if.tx_data, $time);
               end else begin
                  check("tx_byte", {24'd0, uart_if.tx_data}, {24'd0, tx_q.pop_front()});
                  chk_drop = (tx_q.size() == 0);
               end
            end
            prev_stall = uart_if.tx_valid && !uart_if.tx_ready;
            prev_data  = uart_if.tx_data;
            if (time_valid) begin
               if (time_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL time_valid: got pulse expected none at %0t", $time);
               end else begin
                  check("time_fields", {2'd0, sec_bcd, min_bcd, hour_bcd, day_bcd},
                        {2'd0, time_q.pop_front()});
               end
            end
            if (sym_err) begin
               if (err_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL sym_err: got pulse expected none at %0t", $time);
               end else begin
                  check("sym_err_state", {30'd0, sync_state}, {30'd0, err_q.pop_front()});
               end
            end
         end
      end
   end

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // -------------------------------------------------------------- stimulus
   initial begin
      uart_if.rx_data  = 8'h00;
      uart_if.rx_valid = 1'b0;
      tx_mode = 0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_tx", {23'd0, uart_if.tx_valid, uart_if.tx_data}, 32'd0);
      check("rst_flags", {28'd0, locked, sym_err, time_valid, overrun}, 32'd0);
      check("rst_fields", {2'd0, sec_bcd, min_bcd, hour_bcd, day_bcd}, 32'd0);
      check("rst_state", {30'd0, sync_state}, {30'd0, ST_HUNT});
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_state", {30'd0, sync_state}, {30'd0, ST_HUNT});

      // Reference frame, tx_ready held high
      tx_mode = 1;
      time_q.push_back(TIME_A);
      push_report_a();
      send_str("P");
      check("armed_after_p1", {30'd0, sync_state}, {30'd0, ST_ARMED});
      check("not_locked_p1", {31'd0, locked}, 32'd0);
      send_str("P");
      check("locked_after_p2", {31'd0, locked}, 32'd1);
      send_frame_a();
      wait_tx_done(200);
      check("fields_hold", {2'd0, sec_bcd, min_bcd, hour_bcd, day_bcd}, {2'd0, TIME_A});
      check("no_overrun_1", {31'd0, overrun}, 32'd0);

      // Same frame, tx_ready 1-in-3
      do_reset();
      tx_mode = 2;
      time_q.push_back(TIME_A);
      push_report_a();
      send_str("PP");
      send_frame_a();
      wait_tx_done(300);
      check("no_overrun_2", {31'd0, overrun}, 32'd0);

      // Error symbols in HUNT/ARMED, data bit at marker 19
      do_reset();
      tx_mode = 1;
      send_str("x");
      check("hunt_ignores_err", {30'd0, sync_state}, {30'd0, ST_HUNT});
      send_str("P");
      err_q.push_back(ST_HUNT);
      send_str("x");
      check("armed_err_to_hunt", {30'd0, sync_state}, {30'd0, ST_HUNT});
      send_str("PP");
      send_str("00010000P000100010");
      err_q.push_back(ST_HUNT);
      send_str("1");
      check("bit_at_marker_unlock", {31'd0, locked}, 32'd0);
      check("bit_at_marker_state", {30'd0, sync_state}, {30'd0, ST_HUNT});

      // P at idx 12 then P relocks at idx 0
      send_str("PP");
      send_str("00000000P00");
      err_q.push_back(ST_ARMED);
      send_str("P");
      check("p_off_marker_state", {30'd0, sync_state}, {30'd0, ST_ARMED});
      send_str("P");
      check("relock", {31'd0, locked}, 32'd1);
      send_str("00000000P");
      check("relock_idx0", {30'd0, sync_state}, {30'd0, ST_LOCKED});
      repeat (3) @(posedge clk);
      #1;

      // Two publishes with tx_ready low: overrun, snapshot kept
      do_reset();
      tx_mode = 0;
      time_q.push_back(TIME_A);
      send_str("PP");
      send_frame_a();
      check("overrun_clear_first", {31'd0, overrun}, 32'd0);
      for (int i = 0; i < 5; i++) send_str("000000000P");
      send_str("P");
      check("relock_after_99", {31'd0, locked}, 32'd1);
      time_q.push_back(TIME_B);
      send_frame_b();
      check("overrun_set", {31'd0, overrun}, 32'd1);
      check("snapshot_kept", {23'd0, uart_if.tx_valid, uart_if.tx_data}, {23'd0, 1'b1, 8'h30});
      check("fields_updated", {22'd0, day_bcd}, 32'h151);
      push_report_a();
      tx_mode = 1;
      wait_tx_done(200);
      check("overrun_sticky", {31'd0, overrun}, 32'd1);

      // Reset in the middle of a stalled report
      do_reset();
      tx_mode = 0;
      time_q.push_back(TIME_A);
      send_str("PP");
      send_frame_a();
      repeat (2) @(posedge clk);
      #1;
      check("report_pending", {31'd0, uart_if.tx_valid}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst_drops_tx_valid", {31'd0, uart_if.tx_valid}, 32'd0);
      tx_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      check("time_q_drained", time_q.size(), 32'd0);
      check("tx_q_drained", tx_q.size(), 32'd0);
      check("err_q_drained", err_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
